// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: bypass muxing, hazard detection, stall accounting and the EX pipeline register.
// Optional macro IDEX_OPERAND_FWD_EN: only loads stall, and ALU results in EX are flagged for self-forwarding.
module idex_operand_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [5:0]  id_ra,
   input  logic [5:0]  id_rb,
   input  logic [5:0]  id_rw,
   input  logic        id_regwe,
   input  logic        id_load,
   input  logic [31:0] rf_out1,
   input  logic [31:0] rf_out2,
   input  logic        mem_regwe,
   input  logic [5:0]  mem_rw,
   input  logic        mem_load,
   input  logic [31:0] mem_result,
   input  logic        wb_regwe,
   input  logic [5:0]  wb_rw,
   input  logic [31:0] wb_din,
   input  logic        flush,
   input  logic        ex_ready,
   output logic        ex_valid,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [5:0]  ex_rw,
   output logic        ex_regwe,
   output logic        ex_load,
   output logic        ex_fwd_a,
   output logic        ex_fwd_b,
   output logic [15:0] stall_count
);

   logic        advance;
   logic        ex_hit_en;
   logic        mem_hit_en;
   logic        hazard_a;
   logic        hazard_b;
   logic        hazard;
   logic        take;
   logic        stalled;
   logic [31:0] op_a;
   logic [31:0] op_b;

   // MEM result outranks WB data, which outranks the register file read.
   function automatic logic [31:0] select_operand(
      input logic [5:0]  src,
      input logic [31:0] rf_val,
      input logic        m_we,
      input logic [5:0]  m_rw,
      input logic [31:0] m_val,
      input logic        w_we,
      input logic [5:0]  w_rw,
      input logic [31:0] w_val
   );
      logic [31:0] res;
      res = rf_val;
      if (m_we && (m_rw == src))
         res = m_val;
      else if (w_we && (w_rw == src))
         res = w_val;
      return res;
   endfunction

   function automatic logic src_hazard(
      input logic [5:0] src,
      input logic       ex_en,
      input logic [5:0] e_rw,
      input logic       mem_en,
      input logic [5:0] m_rw
   );
      return (ex_en && (e_rw == src)) || (mem_en && (m_rw == src));
   endfunction

`ifdef IDEX_OPERAND_FWD_EN
   // Only loads are unresolved: ALU results forward from EX or MEM.
   assign ex_hit_en  = ex_valid & ex_regwe & ex_load;
   assign mem_hit_en = mem_regwe & mem_load;
`else
   logic unused_mem_load;

   assign unused_mem_load = mem_load;
   assign ex_hit_en       = ex_valid & ex_regwe;
   assign mem_hit_en      = mem_regwe;
`endif

   always_comb begin
      op_a     = select_operand(id_ra, rf_out1, mem_regwe, mem_rw, mem_result, wb_regwe, wb_rw, wb_din);
      op_b     = select_operand(id_rb, rf_out2, mem_regwe, mem_rw, mem_result, wb_regwe, wb_rw, wb_din);
      hazard_a = src_hazard(id_ra, ex_hit_en, ex_rw, mem_hit_en, mem_rw);
      hazard_b = src_hazard(id_rb, ex_hit_en, ex_rw, mem_hit_en, mem_rw);
   end

   assign hazard   = hazard_a | hazard_b;
   assign advance  = ~ex_valid | ex_ready;
   assign id_ready = flush | (advance & ~hazard);
   assign take     = advance & id_valid & ~hazard & ~flush;
   assign stalled  = id_valid & ~id_ready;

   // Operand payload only changes on an accepted instruction; bubbles just clear the control bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid <= 1'b0;
         ex_regwe <= 1'b0;
         ex_load  <= 1'b0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_rw    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_regwe <= 1'b0;
         ex_load  <= 1'b0;
      end else if (advance) begin
         if (take) begin
            ex_valid <= 1'b1;
            ex_regwe <= id_regwe;
            ex_load  <= id_load;
            ex_a     <= op_a;
            ex_b     <= op_b;
            ex_rw    <= id_rw;
         end else begin
            ex_valid <= 1'b0;
            ex_regwe <= 1'b0;
            ex_load  <= 1'b0;
         end
      end
   end

`ifdef IDEX_OPERAND_FWD_EN
   logic ex_alu_hit;

   assign ex_alu_hit = ex_valid & ex_regwe & ~ex_load;

   // The ALU reuses its own previous result when the producer is still sitting in EX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_fwd_a <= 1'b0;
         ex_fwd_b <= 1'b0;
      end else if (flush) begin
         ex_fwd_a <= 1'b0;
         ex_fwd_b <= 1'b0;
      end else if (advance) begin
         if (take) begin
            ex_fwd_a <= ex_alu_hit && (id_ra == ex_rw);
            ex_fwd_b <= ex_alu_hit && (id_rb == ex_rw);
         end else begin
            ex_fwd_a <= 1'b0;
            ex_fwd_b <= 1'b0;
         end
      end
   end
`else
   assign ex_fwd_a = 1'b0;
   assign ex_fwd_b = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_count <= '0;
      else if (stalled && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end

endmodule
